// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock, with a start/busy/done handshake.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  sreg, sreg_next;
  logic [BW-1:0]     acc, acc_next, acc_adj;
  logic [CW-1:0]     cnt, cnt_next;
  logic [BW-1:0]     bcd_next;
  logic              busy_next, done_next;
  logic [BW+WIDTH-1:0] shifted;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      sreg  <= sreg_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      bcd   <= bcd_next;
      busy  <= busy_next;
      done  <= done_next;
    end
  end

  // Next-state, digit correction and shift
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    acc_next   = acc;
    cnt_next   = cnt;
    bcd_next   = bcd;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    acc_adj    = acc;

    // All digits corrected in parallel from pre-shift values
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, sreg} << 1;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          sreg_next  = bin;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = SHIFT;
          busy_next  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        acc_next  = shifted[BW+WIDTH-1:WIDTH];
        sreg_next = shifted[WIDTH-1:0];
        cnt_next  = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          bcd_next   = shifted[BW+WIDTH-1:WIDTH];
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values, random values,
// ignored restarts, continuous back-to-back streaming and reset abort.
module tb_bin2bcd_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [39:0] bcd;

  int errors;
  int checks;

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Decimal digits by repeated division
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0]     r;
    longint unsigned x;
    r = '0;
    x = longint'(v);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 40'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h, required busy=0 done=0 bcd=0", busy, done, bcd);
    end
  endtask

  // One full conversion: checks latency, busy length, single done, result
  task automatic convert(input string name, input logic [31:0] v);
    logic [39:0] exp_bcd;
    int busy_cnt;
    int guard;
    exp_bcd = to_bcd(v);
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    bin   = $urandom;
    busy_cnt = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      if (done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL %s_overlap: done=%b while busy=1", name, done);
      end
      busy_cnt++;
      step();
      guard++;
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL %s_busy_len: busy cycles=%0d, required 32", name, busy_cnt);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    checks++;
    if (bcd !== exp_bcd) begin
      errors++;
      $display("FAIL %s_bcd: bcd=%h, required %h", name, bcd, exp_bcd);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || bcd !== exp_bcd) begin
      errors++;
      $display("FAIL %s_after: done=%b busy=%b bcd=%h, required 0 0 %h", name, done, busy, bcd, exp_bcd);
    end
  endtask

  task automatic test_corners();
    logic [39:0] snap;
    bit bad;
    convert("zero", 32'd0);
    convert("dec1234567890", 32'h499602D2);
    convert("max", 32'hFFFFFFFF);
    snap = bcd;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (snap[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL max_nibbles: bcd=%h has a digit above 9", snap);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      convert("random", $urandom);
    end
    convert("pow10", 32'd1000000000);
    convert("nines", 32'd999999999);
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    start = 1'b1;
    bin   = 32'd42;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int k = 1; k < 40; k++) begin
      if (k == 3 || k == 10 || k == 20 || k == 31) begin
        start = 1'b1;
        bin   = 32'd99;
      end else begin
        start = 1'b0;
        bin   = 32'd99;
      end
      step();
      if (done === 1'b1) done_cnt++;
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL ignore_done_count: dones=%0d, required 1", done_cnt);
    end
    checks++;
    if (bcd !== 40'h0000000042) begin
      errors++;
      $display("FAIL ignore_bcd: bcd=%h, required 0000000042", bcd);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b, required 0", busy);
    end
  endtask

  // start held high; bin follows a free-running counter advancing every edge
  task automatic test_back_to_back();
    logic [31:0] base;
    int phase;
    int done_cnt;
    int last_done;
    bit exp_busy, exp_done;
    base = $urandom;
    done_cnt = 0;
    last_done = -1;
    start = 1'b1;
    bin   = base;
    for (int k = 0; k < 300; k++) begin
      step();
      bin = base + 32'(k + 1);
      phase = k % 33;
      exp_busy = (phase < 32);
      exp_done = (phase == 32);
      if (busy !== exp_busy || done !== exp_done) begin
        checks++;
        errors++;
        $display("FAIL stream_handshake: edge=%0d busy=%b done=%b, required busy=%b done=%b", k, busy, done, exp_busy, exp_done);
      end
      if (exp_done) begin
        checks++;
        if (bcd !== to_bcd(base + 32'(k - 32))) begin
          errors++;
          $display("FAIL stream_bcd: edge=%0d bcd=%h, required %h", k, bcd, to_bcd(base + 32'(k - 32)));
        end
      end
      if (done === 1'b1) begin
        if (last_done >= 0) begin
          checks++;
          if (k - last_done != 33) begin
            errors++;
            $display("FAIL stream_period: done period=%0d, required 33", k - last_done);
          end
        end
        last_done = k;
        done_cnt++;
      end
    end
    checks++;
    if (done_cnt != 9) begin
      errors++;
      $display("FAIL stream_done_count: dones=%0d, required 9", done_cnt);
    end
    start = 1'b0;
    for (int g = 0; g < 40 && (busy === 1'b1 || done === 1'b1); g++) step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_abort();
    int done_cnt;
    start = 1'b1;
    bin   = 32'd1000;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 40'h0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b bcd=%h, required 0 0 0", busy, done, bcd);
    end
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0 || bcd !== 40'h0) begin
      errors++;
      $display("FAIL abort_quiet: activity cycles=%0d bcd=%h, required 0 and 0", done_cnt, bcd);
    end
    convert("after_abort", 32'd1000);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    start  = 1'b0;
    bin    = '0;
    test_reset();
    test_corners();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
